// File: rtl/fabric_common_pkg.sv
// rtl/fabric_common_pkg.sv - shared scheduler state type and error codes
package fabric_common;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_DRAIN  = 2'd2
  } sched_state_e;

  localparam logic [15:0] RT_DATAFLOW_STREAM_SCHED_SPURIOUS = 16'h0001;
  localparam logic [15:0] RT_DATAFLOW_STREAM_SCHED_DESYNC   = 16'h0002;

endpackage

// File: rtl/fabric_rr_pick.sv
// rtl/fabric_rr_pick.sv - combinational round-robin picker, search starts at ptr_i and wraps
module fabric_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/dataflow_stream_sched.sv
// rtl/dataflow_stream_sched.sv - arbitrates stream-engine jobs among requesters and routes the index stream back to the owner
module dataflow_stream_sched
  import fabric_common::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_start_data,
  input  logic [NUM_REQ*WIDTH-1:0] req_step_data,
  input  logic [NUM_REQ*WIDTH-1:0] req_bound_data,
  output logic                     eng_start_valid,
  output logic                     eng_step_valid,
  output logic                     eng_bound_valid,
  input  logic                     eng_start_ready,
  input  logic                     eng_step_ready,
  input  logic                     eng_bound_ready,
  output logic [WIDTH-1:0]         eng_start_data,
  output logic [WIDTH-1:0]         eng_step_data,
  output logic [WIDTH-1:0]         eng_bound_data,
  input  logic                     eng_index_valid,
  input  logic [WIDTH-1:0]         eng_index_data,
  output logic                     eng_index_ready,
  input  logic                     eng_cont_valid,
  input  logic                     eng_cont_data,
  output logic                     eng_cont_ready,
  output logic [NUM_REQ-1:0]       out_valid,
  input  logic [NUM_REQ-1:0]       out_ready,
  output logic [WIDTH-1:0]         out_index,
  output logic                     out_last,
  output logic [IDW-1:0]           owner_id,
  output logic                     error_valid,
  output logic [15:0]              error_code
);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] bound_q, bound_d;
  logic             err_valid_q, err_valid_d;
  logic [15:0]      err_code_q, err_code_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   sel_start, sel_step, sel_bound;
  logic               joint_valid, beat;

  fabric_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant is one-hot, so an AND-OR mux selects the winner's operands.
  always_comb begin
    sel_start = '0;
    sel_step  = '0;
    sel_bound = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_start = sel_start | req_start_data[i*WIDTH +: WIDTH];
        sel_step  = sel_step  | req_step_data[i*WIDTH +: WIDTH];
        sel_bound = sel_bound | req_bound_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign joint_valid = eng_index_valid && eng_cont_valid;
  assign beat        = (state_q == S_DRAIN) && joint_valid && out_ready[owner_q];

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    start_d         = start_q;
    step_d          = step_q;
    bound_d         = bound_q;
    req_ready       = '0;
    eng_start_valid = 1'b0;
    eng_step_valid  = 1'b0;
    eng_bound_valid = 1'b0;
    eng_index_ready = 1'b0;
    out_valid       = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          owner_d = pick_idx;
          start_d = sel_start;
          step_d  = sel_step;
          bound_d = sel_bound;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start_valid = 1'b1;
        eng_step_valid  = 1'b1;
        eng_bound_valid = 1'b1;
        if (eng_start_ready && eng_step_ready && eng_bound_ready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid[owner_q] = joint_valid;
        eng_index_ready    = beat;
        if (beat && !eng_cont_data) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == IDW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Error capture only observes; it never feeds back into the FSM.
  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if (!err_valid_q) begin
      if (state_q != S_DRAIN && (eng_index_valid || eng_cont_valid)) begin
        err_valid_d = 1'b1;
        err_code_d  = RT_DATAFLOW_STREAM_SCHED_SPURIOUS;
      end else if (state_q == S_DRAIN && (eng_index_valid != eng_cont_valid)) begin
        err_valid_d = 1'b1;
        err_code_d  = RT_DATAFLOW_STREAM_SCHED_DESYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      start_q     <= '0;
      step_q      <= '0;
      bound_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      start_q     <= start_d;
      step_q      <= step_d;
      bound_q     <= bound_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign eng_cont_ready = eng_index_ready;
  assign eng_start_data = start_q;
  assign eng_step_data  = step_q;
  assign eng_bound_data = bound_q;
  assign out_index      = eng_index_data;
  assign out_last       = !eng_cont_data;
  assign owner_id       = owner_q;
  assign error_valid    = err_valid_q;
  assign error_code     = err_code_q;

endmodule

// File: tb/tb_dataflow_stream_sched.sv
// tb/tb_dataflow_stream_sched.sv - directed bench with a behavioural slt stream engine
module tb_dataflow_stream_sched;
  localparam int WIDTH = 32;
  localparam int NR    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]       req_valid, req_ready, out_valid, out_ready;
  logic [NR*WIDTH-1:0] req_start_data, req_step_data, req_bound_data;
  logic eng_start_valid, eng_step_valid, eng_bound_valid;
  logic eng_start_ready, eng_step_ready, eng_bound_ready;
  logic [WIDTH-1:0] eng_start_data, eng_step_data, eng_bound_data;
  logic eng_index_valid, eng_index_ready, eng_cont_valid, eng_cont_data, eng_cont_ready;
  logic [WIDTH-1:0] eng_index_data, out_index;
  logic out_last, error_valid;
  logic [1:0]  owner_id;
  logic [15:0] error_code;

  logic e_active, spur, drop_cont, bp_en;
  logic [WIDTH-1:0] e_cur, e_step, e_bound;
  int n_vec, n_bad, bp_bad, stall_bad;

  typedef struct { int owner; logic [WIDTH-1:0] idx; logic last; } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  dataflow_stream_sched #(.WIDTH(WIDTH), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start_data(req_start_data), .req_step_data(req_step_data), .req_bound_data(req_bound_data),
    .eng_start_valid(eng_start_valid), .eng_step_valid(eng_step_valid), .eng_bound_valid(eng_bound_valid),
    .eng_start_ready(eng_start_ready), .eng_step_ready(eng_step_ready), .eng_bound_ready(eng_bound_ready),
    .eng_start_data(eng_start_data), .eng_step_data(eng_step_data), .eng_bound_data(eng_bound_data),
    .eng_index_valid(eng_index_valid), .eng_index_data(eng_index_data), .eng_index_ready(eng_index_ready),
    .eng_cont_valid(eng_cont_valid), .eng_cont_data(eng_cont_data), .eng_cont_ready(eng_cont_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_last(out_last),
    .owner_id(owner_id), .error_valid(error_valid), .error_code(error_code)
  );

  assign eng_index_valid = e_active | spur;
  assign eng_cont_valid  = e_active & ~drop_cont;
  assign eng_index_data  = e_cur;
  assign eng_cont_data   = ($signed(e_cur + e_step) < $signed(e_bound));

  // Engine: handshakes sampled mid-cycle, state advanced just after the edge.
  initial begin
    logic fl, fi, fc;
    e_active = 1'b0; e_cur = '0; e_step = '0; e_bound = '0;
    forever begin
      @(negedge clk);
      fl = eng_start_valid && eng_start_ready && eng_step_valid && eng_step_ready
           && eng_bound_valid && eng_bound_ready;
      fi = eng_index_valid && eng_index_ready && eng_cont_valid && eng_cont_ready;
      fc = eng_cont_data;
      @(posedge clk);
      #1;
      if (!rst_n) e_active = 1'b0;
      else if (fl) begin
        e_cur = eng_start_data; e_step = eng_step_data; e_bound = eng_bound_data; e_active = 1'b1;
      end else if (fi) begin
        if (!fc) e_active = 1'b0;
        e_cur = e_cur + e_step;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++)
      if (out_valid[i] && out_ready[i]) sb.push_back('{i, out_index, out_last});
    if (bp_en && (eng_index_ready !== (out_ready[1] && eng_index_valid && eng_cont_valid)
                  || eng_cont_ready !== eng_index_ready || (out_valid & 4'b1101) != 0))
      bp_bad++;
  end

  always @(posedge clk) if (bp_en) begin #1; out_ready[1] = ~out_ready[1]; end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n();
    @(negedge clk); #2;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 300 && sb.size() < n; c++) wait_n();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] s, input logic [31:0] st, input logic [31:0] b);
    req_start_data[i*WIDTH +: WIDTH] = s;
    req_step_data[i*WIDTH +: WIDTH]  = st;
    req_bound_data[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wait_n(); @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic issue(input logic [NR-1:0] rv);
    req_valid = rv; wait_n(); @(posedge clk); #1; req_valid = '0;
  endtask

  task automatic check_beats(input string tag, input int owner, input logic [31:0] s,
                             input logic [31:0] st, input int n);
    chk($sformatf("%s_count", tag), sb.size(), n);
    for (int k = 0; k < n && k < sb.size(); k++) begin
      chk($sformatf("%s_owner%0d", tag, k), sb[k].owner, owner);
      chk($sformatf("%s_idx%0d", tag, k), sb[k].idx, s + st * k);
      chk($sformatf("%s_last%0d", tag, k), sb[k].last, (k == n-1));
    end
    sb.delete();
  endtask

  initial begin
    n_vec = 0; n_bad = 0; bp_bad = 0; stall_bad = 0;
    spur = 0; drop_cont = 0; bp_en = 0;
    req_valid = '0; out_ready = '1;
    req_start_data = '0; req_step_data = '0; req_bound_data = '0;
    eng_start_ready = 1; eng_step_ready = 1; eng_bound_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    wait_n();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eng_start_valid", eng_start_valid, 0);
    chk("rst_eng_index_ready", eng_index_ready, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_error", {error_valid, error_code}, 0);
    chk("rst_operand", eng_start_data, 0);
    @(posedge clk); #1; rst_n = 1;

    // single job: 0,1,2
    set_op(0, 0, 1, 3);
    req_valid = 4'b0001; wait_n();
    chk("t1_req_ready", req_ready, 4'b0001);
    @(posedge clk); #1; req_valid = '0;
    wait_n();
    chk("t1_launch_valid", {eng_start_valid, eng_step_valid, eng_bound_valid}, 3'b111);
    chk("t1_launch_ops", {eng_start_data, eng_step_data, eng_bound_data}, {32'd0, 32'd1, 32'd3});
    wait_beats(3);
    check_beats("t1", 0, 0, 1, 3);
    wait_n();
    chk("t1_idle_valid", {eng_start_valid, out_valid, eng_index_ready}, 0);
    req_valid = 4'b0011; #1;
    chk("t1_rr_next", req_ready, 4'b0010);
    req_valid = '0;

    // contention: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 10*i, 1, 10*i + 1);
    req_valid = 4'b1111;
    wait_beats(5);
    req_valid = '0;
    chk("t2_count", sb.size(), 5);
    for (int k = 0; k < 5 && k < sb.size(); k++) begin
      chk($sformatf("t2_owner%0d", k), sb[k].owner, k % 4);
      chk($sformatf("t2_idx%0d", k), sb[k].idx, 10 * (k % 4));
      chk($sformatf("t2_last%0d", k), sb[k].last, 1);
    end
    sb.delete();

    // backpressure on requester 1: 5,7,9,11,13
    set_op(1, 5, 2, 15);
    bp_en = 1;
    issue(4'b0010);
    wait_beats(5);
    bp_en = 0; out_ready = '1;
    chk("t3_ready_follow", bp_bad, 0);
    check_beats("t3", 1, 5, 2, 5);

    // launch stall on requester 2: 7,10,13
    eng_start_ready = 0;
    set_op(2, 7, 3, 14);
    issue(4'b0100);
    for (int c = 0; c < 5; c++) begin
      wait_n();
      if (eng_start_valid !== 1 || eng_start_data !== 7 || eng_step_data !== 3
          || eng_bound_data !== 14 || out_valid !== 0) stall_bad++;
    end
    chk("t4_stall_stable", stall_bad, 0);
    chk("t4_owner", owner_id, 2);
    @(posedge clk); #1; eng_start_ready = 1;
    wait_beats(3);
    check_beats("t4", 2, 7, 3, 3);

    // spurious index in idle
    chk("t5_no_err", error_valid, 0);
    @(posedge clk); #1; spur = 1;
    @(posedge clk); #1; spur = 0;
    wait_n();
    chk("t5_err", {error_valid, error_code}, {1'b1, 16'h0001});
    set_op(3, 0, 1, 2);
    issue(4'b1000);
    wait_beats(2);
    check_beats("t5", 3, 0, 1, 2);
    chk("t5_err_sticky", error_code, 16'h0001);

    // desync: index without cont stalls, flags error
    do_reset();
    drop_cont = 1;
    set_op(0, 0, 1, 3);
    issue(4'b0001);
    repeat (4) wait_n();
    chk("t6_err", {error_valid, error_code}, {1'b1, 16'h0002});
    chk("t6_no_beat", sb.size(), 0);
    chk("t6_out_valid", out_valid, 0);
    @(posedge clk); #1; drop_cont = 0;
    wait_beats(3);
    check_beats("t6", 0, 0, 1, 3);

    // reset mid 5-index job, then fresh job from req2
    do_reset();
    set_op(0, 0, 1, 5);
    issue(4'b0001);
    wait_beats(2);
    rst_n = 0;
    wait_n();
    chk("t7_outs_zero", {out_valid, eng_index_ready, eng_cont_ready, eng_start_valid, req_ready}, 0);
    chk("t7_owner", owner_id, 0);
    chk("t7_err", {error_valid, error_code}, 0);
    wait_n();
    chk("t7_no_more", sb.size(), 2);
    sb.delete();
    @(posedge clk); #1; rst_n = 1;
    set_op(2, 4, 4, 12);
    issue(4'b0100);
    wait_beats(2);
    check_beats("t7", 2, 4, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
